l0_cache_write_ctrl: RTL and testbench
======================================

Name: l0_cache_write_ctrl

Overview:
- Owns the single write port of the L0 data cache RAM (tag, per-byte valid bits, data) and arbitrates it between three sources: invalidation sweeps, store write-through updates and load-miss fills.
- Performs a full-cache invalidation sweep after reset and on a fence.i/software flush request.
- Holds o_busy high while sweeping so the pipeline stalls loads and stores.
- Sits beside the hit-detection logic in the L0 cache; the read side is untouched except for one read index used for store merge.

Parameters:
- XLEN, 32, data word width; byte lanes = XLEN/8
- CacheDepth, 128, number of cache entries (power of two)
- CacheTagWidth, 7, stored tag width; must equal MEM_BYTE_ADDR_WIDTH-2-$clog2(CacheDepth)
- MEM_BYTE_ADDR_WIDTH, 16, byte-address width of backing memory
- MMIO_ADDR, 32'h4000_0000, addresses >= this are uncacheable

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_flush_req  in  1  single-cycle flush request
- o_flush_done  out  1  one-cycle pulse when the requested flush completes
- o_busy  out  1  sweep in progress; the pipeline must stall cache accesses
- i_store_valid  in  1  store presented
- o_store_ready  out  1  store accepted this cycle
- i_store_addr  in  XLEN  store byte address
- i_store_byte_en  in  XLEN/8  bytes written
- i_store_data  in  XLEN  store data, lane-aligned
- i_fill_valid  in  1  fill word presented (load-miss return)
- o_fill_ready  out  1  fill accepted this cycle
- i_fill_addr  in  XLEN  fill word address
- i_fill_data  in  XLEN  full word from memory
- o_rd_index  out  $clog2(CacheDepth)  read index for merge (= store index)
- i_rd_tag  in  CacheTagWidth  tag at o_rd_index, combinational read
- i_rd_valid_bits  in  XLEN/8  valid bits at o_rd_index
- o_wr_en  out  1  RAM write strobe
- o_wr_index  out  $clog2(CacheDepth)  entry written
- o_wr_tag  out  CacheTagWidth  tag written
- o_wr_valid_bits  out  XLEN/8  valid bits written
- o_wr_data  out  XLEN  data written
- o_wr_data_byte_en  out  XLEN/8  data lane write enables (tag and valid bits are always written whole)

Behaviour:
- Address decode (store and fill):
  - index = addr[IdxW+1:2]
  - tag = addr[MEM_BYTE_ADDR_WIDTH-1:IdxW+2]
  - cacheable = (addr < MMIO_ADDR) && (addr[XLEN-1:MEM_BYTE_ADDR_WIDTH] == 0)
- States: INIT_SWEEP, IDLE, FLUSH_SWEEP. Reset enters INIT_SWEEP with sweep counter = 0. flush_pending resets to 0.
- Reset values of outputs:
  - o_busy = 1
  - o_flush_done = 0
  - o_store_ready = 0
  - o_fill_ready = 0
  - o_wr_en = 1 (sweep write of index 0)
- Sweep (either sweep state):
  - Each cycle: o_wr_en=1, o_wr_index=counter, tag=0, valid_bits=0, data_byte_en=0. Counter then increments.
  - On the write of index CacheDepth-1 the next state is IDLE. INIT_SWEEP never pulses o_flush_done.
  - FLUSH_SWEEP pulses o_flush_done in the first IDLE cycle, so completion occurs CacheDepth+1 cycles after entry.
  - o_busy=1 and both ready outputs are 0 throughout.
- Reset mid-sweep: restart INIT_SWEEP at index 0 and drop any pending flush.
- IDLE + i_flush_req: FLUSH_SWEEP begins the next cycle at index 0. A store or fill presented in that same cycle is still serviced.
- i_flush_req during a sweep: set flush_pending. When the sweep finishes, go directly to a fresh FLUSH_SWEEP instead of IDLE; the first sweep's o_flush_done is suppressed and a single o_flush_done pulse follows the final sweep.
- IDLE priority: store > fill.
  - o_store_ready = 1
  - o_fill_ready = !i_store_valid
- Store handshake (i_store_valid && o_store_ready):
  - Uncacheable: accepted, no write.
  - Cacheable, i_rd_tag == tag: valid_bits = i_rd_valid_bits | byte_en.
  - Cacheable, tag mismatch: valid_bits = byte_en.
  - In both cacheable cases, data_byte_en = byte_en and tag = store tag.
- Fill handshake:
  - Cacheable: write tag, valid_bits = all ones, data_byte_en = all ones.
  - Uncacheable: accepted, no write.
- Fill not accepted (store wins): the fill is not written and the requester must retry; the controller does not buffer it.
- o_wr_en = 0 in IDLE when there is no accepted cacheable request.

Optional Feature:
- Macro: L0_CACHE_WRITE_STATS_EN.
- Defined:
  - Adds three 32-bit saturating counters, reset to 0 and cleared only by i_rst: o_stat_flushes (incremented per o_flush_done), o_stat_fill_conflicts (fill blocked by store) and o_stat_store_merges (tag-hit stores).
  - Three extra output ports carry the counters.
- Undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package l0_cache_pkg:
  - CacheIndexWidth localparam
  - l0_cache_entry_t struct {tag, valid_bits, data}
  - l0_wr_state_e enum {INIT_SWEEP, IDLE, FLUSH_SWEEP}
- Sub-module l0_cache_addr_decode:
  - Combinational index/tag/cacheable split.
  - Instantiated twice (store, fill).
  - Reusable by the load hit path.

Test Plan:
- Release i_rst: o_wr_en=1 for exactly 128 cycles, indices 0..127, all valid_bits=0; o_busy drops on cycle 129; no o_flush_done.
- IDLE, store addr 0x0000_0104, byte_en=4'b0011, i_rd_tag matches, i_rd_valid_bits=4'b1100: o_wr_index=65, valid_bits=4'b1111, data_byte_en=4'b0011.
- Same-cycle store index 3 and fill index 9: o_fill_ready=0, single write to index 3; the fill is accepted on the following cycle.
- Store to 0x4000_0000 and fill from 0x0001_0000: both accepted, o_wr_en stays 0.
- i_flush_req, then a second i_flush_req at sweep index 50: two consecutive 128-entry sweeps and exactly one o_flush_done pulse, after the second sweep.
- Assert i_rst at sweep index 70: the next cycle writes index 0; a pending flush is cleared.

Source files
------------

// File: rtl/l0_cache_pkg.sv
// Shared types and default geometry for the L0 data cache write side.
package l0_cache_pkg;

  localparam int L0Xlen          = 32;
  localparam int L0CacheDepth    = 128;
  localparam int L0MemAddrWidth  = 16;
  localparam int CacheIndexWidth = $clog2(L0CacheDepth);
  localparam int L0TagWidth      = L0MemAddrWidth - 2 - CacheIndexWidth;

  typedef struct packed {
    logic [L0TagWidth-1:0] tag;
    logic [L0Xlen/8-1:0]   valid_bits;
    logic [L0Xlen-1:0]     data;
  } l0_cache_entry_t;

  typedef enum logic [1:0] {
    INIT_SWEEP  = 2'd0,
    IDLE        = 2'd1,
    FLUSH_SWEEP = 2'd2
  } l0_wr_state_e;

endpackage

// File: rtl/l0_cache_addr_decode.sv
// Splits a byte address into cache index, stored tag and cacheable flag.
module l0_cache_addr_decode #(
  parameter int               XLEN                = 32,
  parameter int               IdxW                = 7,
  parameter int               TagW                = 7,
  parameter int               MEM_BYTE_ADDR_WIDTH = 16,
  parameter logic [XLEN-1:0]  MMIO_ADDR           = 32'h4000_0000
) (
  input  logic [XLEN-1:0] i_addr,
  output logic [IdxW-1:0] o_index,
  output logic [TagW-1:0] o_tag,
  output logic            o_cacheable
);

  logic unused_byte_offset;

  assign o_index     = i_addr[IdxW+1:2];
  assign o_tag       = i_addr[MEM_BYTE_ADDR_WIDTH-1:IdxW+2];
  // Anything beyond the backing memory or in the MMIO window bypasses the cache.
  assign o_cacheable = (i_addr < MMIO_ADDR) &&
                       (i_addr[XLEN-1:MEM_BYTE_ADDR_WIDTH] == {(XLEN-MEM_BYTE_ADDR_WIDTH){1'b0}});
  assign unused_byte_offset = ^i_addr[1:0];

endmodule

// File: rtl/l0_cache_write_ctrl.sv
// L0 cache RAM write-port owner: invalidation sweeps, store write-through, fills.
// Optional counters enabled by defining L0_CACHE_WRITE_STATS_EN.
module l0_cache_write_ctrl
  import l0_cache_pkg::*;
#(
  parameter int              XLEN                = L0Xlen,
  parameter int              CacheDepth          = L0CacheDepth,
  parameter int              CacheTagWidth       = L0TagWidth,
  parameter int              MEM_BYTE_ADDR_WIDTH = L0MemAddrWidth,
  parameter logic [XLEN-1:0] MMIO_ADDR           = 32'h4000_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush_req,
  output logic                          o_flush_done,
  output logic                          o_busy,
  input  logic                          i_store_valid,
  output logic                          o_store_ready,
  input  logic [XLEN-1:0]               i_store_addr,
  input  logic [XLEN/8-1:0]             i_store_byte_en,
  input  logic [XLEN-1:0]               i_store_data,
  input  logic                          i_fill_valid,
  output logic                          o_fill_ready,
  input  logic [XLEN-1:0]               i_fill_addr,
  input  logic [XLEN-1:0]               i_fill_data,
  output logic [$clog2(CacheDepth)-1:0] o_rd_index,
  input  logic [CacheTagWidth-1:0]      i_rd_tag,
  input  logic [XLEN/8-1:0]             i_rd_valid_bits,
  output logic                          o_wr_en,
  output logic [$clog2(CacheDepth)-1:0] o_wr_index,
  output logic [CacheTagWidth-1:0]      o_wr_tag,
  output logic [XLEN/8-1:0]             o_wr_valid_bits,
  output logic [XLEN-1:0]               o_wr_data,
`ifdef L0_CACHE_WRITE_STATS_EN
  output logic [31:0]                   o_stat_flushes,
  output logic [31:0]                   o_stat_fill_conflicts,
  output logic [31:0]                   o_stat_store_merges,
`endif
  output logic [XLEN/8-1:0]             o_wr_data_byte_en
);

  localparam int IdxW  = $clog2(CacheDepth);
  localparam int Lanes = XLEN / 8;

  l0_wr_state_e       state_q, state_d;
  logic [IdxW-1:0]    cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               idle_q, idle_d;

  logic [IdxW-1:0]          st_index, fl_index;
  logic [CacheTagWidth-1:0] st_tag, fl_tag;
  logic                     st_cacheable, fl_cacheable;
  logic                     store_hs, fill_hs, tag_hit, last_idx;

  l0_cache_addr_decode #(
    .XLEN(XLEN), .IdxW(IdxW), .TagW(CacheTagWidth),
    .MEM_BYTE_ADDR_WIDTH(MEM_BYTE_ADDR_WIDTH), .MMIO_ADDR(MMIO_ADDR)
  ) u_store_dec (
    .i_addr(i_store_addr), .o_index(st_index), .o_tag(st_tag), .o_cacheable(st_cacheable)
  );

  l0_cache_addr_decode #(
    .XLEN(XLEN), .IdxW(IdxW), .TagW(CacheTagWidth),
    .MEM_BYTE_ADDR_WIDTH(MEM_BYTE_ADDR_WIDTH), .MMIO_ADDR(MMIO_ADDR)
  ) u_fill_dec (
    .i_addr(i_fill_addr), .o_index(fl_index), .o_tag(fl_tag), .o_cacheable(fl_cacheable)
  );

  assign store_hs = i_store_valid & idle_q;
  assign fill_hs  = i_fill_valid & idle_q & ~i_store_valid;
  assign tag_hit  = (i_rd_tag == st_tag);
  assign last_idx = (cnt_q == IdxW'(CacheDepth - 1));

  assign o_busy        = busy_q;
  assign o_flush_done  = done_q;
  assign o_store_ready = idle_q;
  assign o_fill_ready  = idle_q & ~i_store_valid;
  assign o_rd_index    = st_index;

  // Sweep sequencing; a flush requested mid-sweep chains a fresh sweep and reports once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        if (i_flush_req) begin
          state_d = FLUSH_SWEEP;
          cnt_d   = {IdxW{1'b0}};
          busy_d  = 1'b1;
          idle_d  = 1'b0;
        end else begin
          busy_d  = 1'b0;
          idle_d  = 1'b1;
        end
      end
      INIT_SWEEP, FLUSH_SWEEP: begin
        cnt_d  = cnt_q + 1'b1;
        pend_d = pend_q | i_flush_req;
        if (last_idx) begin
          if (pend_q || i_flush_req) begin
            state_d = FLUSH_SWEEP;
            cnt_d   = {IdxW{1'b0}};
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            idle_d  = 1'b1;
            done_d  = (state_q == FLUSH_SWEEP);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = INIT_SWEEP;
        cnt_d   = {IdxW{1'b0}};
        pend_d  = 1'b0;
        busy_d  = 1'b1;
        idle_d  = 1'b0;
      end
    endcase
  end

  // Control state flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= INIT_SWEEP;
      cnt_q   <= {IdxW{1'b0}};
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      idle_q  <= idle_d;
    end
  end

  // Write-port mux: sweep owns the port, then store, then fill.
  always_comb begin
    o_wr_en           = 1'b0;
    o_wr_index        = st_index;
    o_wr_tag          = {CacheTagWidth{1'b0}};
    o_wr_valid_bits   = {Lanes{1'b0}};
    o_wr_data         = i_store_data;
    o_wr_data_byte_en = {Lanes{1'b0}};
    if (state_q != IDLE) begin
      o_wr_en    = 1'b1;
      o_wr_index = cnt_q;
      o_wr_data  = {XLEN{1'b0}};
    end else if (store_hs) begin
      if (st_cacheable) begin
        o_wr_en           = 1'b1;
        o_wr_tag          = st_tag;
        o_wr_valid_bits   = tag_hit ? (i_rd_valid_bits | i_store_byte_en) : i_store_byte_en;
        o_wr_data_byte_en = i_store_byte_en;
      end else begin
        o_wr_en = 1'b0;
      end
    end else if (fill_hs) begin
      o_wr_index = fl_index;
      o_wr_data  = i_fill_data;
      if (fl_cacheable) begin
        o_wr_en           = 1'b1;
        o_wr_tag          = fl_tag;
        o_wr_valid_bits   = {Lanes{1'b1}};
        o_wr_data_byte_en = {Lanes{1'b1}};
      end else begin
        o_wr_en = 1'b0;
      end
    end else begin
      o_wr_en = 1'b0;
    end
  end

`ifdef L0_CACHE_WRITE_STATS_EN
  logic [31:0] stat_flushes_q, stat_flushes_d;
  logic [31:0] stat_conf_q, stat_conf_d;
  logic [31:0] stat_merge_q, stat_merge_d;

  // Saturating event counters.
  always_comb begin
    stat_flushes_d = stat_flushes_q;
    stat_conf_d    = stat_conf_q;
    stat_merge_d   = stat_merge_q;
    if (done_q && (stat_flushes_q != 32'hFFFF_FFFF)) begin
      stat_flushes_d = stat_flushes_q + 32'd1;
    end else begin
      stat_flushes_d = stat_flushes_q;
    end
    if (i_fill_valid && store_hs && (stat_conf_q != 32'hFFFF_FFFF)) begin
      stat_conf_d = stat_conf_q + 32'd1;
    end else begin
      stat_conf_d = stat_conf_q;
    end
    if (store_hs && st_cacheable && tag_hit && (stat_merge_q != 32'hFFFF_FFFF)) begin
      stat_merge_d = stat_merge_q + 32'd1;
    end else begin
      stat_merge_d = stat_merge_q;
    end
  end

  // Counter flops, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_flushes_q <= 32'd0;
      stat_conf_q    <= 32'd0;
      stat_merge_q   <= 32'd0;
    end else begin
      stat_flushes_q <= stat_flushes_d;
      stat_conf_q    <= stat_conf_d;
      stat_merge_q   <= stat_merge_d;
    end
  end

  assign o_stat_flushes        = stat_flushes_q;
  assign o_stat_fill_conflicts = stat_conf_q;
  assign o_stat_store_merges   = stat_merge_q;
`endif

endmodule

// File: tb/tb_l0_cache_write_ctrl.sv
// Directed self-checking bench for l0_cache_write_ctrl (default geometry).
module tb_l0_cache_write_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_flush_req, o_flush_done, o_busy;
  logic        i_store_valid, o_store_ready;
  logic [31:0] i_store_addr, i_store_data, i_fill_addr, i_fill_data;
  logic [3:0]  i_store_byte_en, i_rd_valid_bits;
  logic        i_fill_valid, o_fill_ready;
  logic [6:0]  o_rd_index, i_rd_tag, o_wr_index, o_wr_tag;
  logic        o_wr_en;
  logic [3:0]  o_wr_valid_bits, o_wr_data_byte_en;
  logic [31:0] o_wr_data;
`ifdef L0_CACHE_WRITE_STATS_EN
  logic [31:0] o_stat_flushes, o_stat_fill_conflicts, o_stat_store_merges;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int bad_a, bad_b, done_a, done_b;

  always #5 clk = ~clk;

  l0_cache_write_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush_req(i_flush_req), .o_flush_done(o_flush_done),
    .o_busy(o_busy), .i_store_valid(i_store_valid), .o_store_ready(o_store_ready),
    .i_store_addr(i_store_addr), .i_store_byte_en(i_store_byte_en), .i_store_data(i_store_data),
    .i_fill_valid(i_fill_valid), .o_fill_ready(o_fill_ready), .i_fill_addr(i_fill_addr),
    .i_fill_data(i_fill_data), .o_rd_index(o_rd_index), .i_rd_tag(i_rd_tag),
    .i_rd_valid_bits(i_rd_valid_bits), .o_wr_en(o_wr_en), .o_wr_index(o_wr_index),
    .o_wr_tag(o_wr_tag), .o_wr_valid_bits(o_wr_valid_bits), .o_wr_data(o_wr_data),
`ifdef L0_CACHE_WRITE_STATS_EN
    .o_stat_flushes(o_stat_flushes), .o_stat_fill_conflicts(o_stat_fill_conflicts),
    .o_stat_store_merges(o_stat_store_merges),
`endif
    .o_wr_data_byte_en(o_wr_data_byte_en)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Walks one 128-entry sweep, pulsing i_flush_req at index req_at.
  task automatic run_sweep(input int req_at, output int bad, output int done_seen);
    bad = 0;
    done_seen = 0;
    for (int i = 0; i < 128; i++) begin
      i_flush_req = (i == req_at);
      @(negedge clk);
      if (!(o_wr_en === 1'b1 && o_wr_index === 7'(i) && o_wr_tag === 7'd0 &&
            o_wr_valid_bits === 4'b0000 && o_wr_data_byte_en === 4'b0000 &&
            o_busy === 1'b1 && o_store_ready === 1'b0 && o_fill_ready === 1'b0))
        bad++;
      if (o_flush_done !== 1'b0) done_seen++;
      next_cycle();
    end
    i_flush_req = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_flush_req = 1'b0;
    i_store_valid = 1'b0; i_store_addr = 32'd0; i_store_byte_en = 4'd0; i_store_data = 32'd0;
    i_fill_valid = 1'b0; i_fill_addr = 32'd0; i_fill_data = 32'd0;
    i_rd_tag = 7'd0; i_rd_valid_bits = 4'd0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_busy", o_busy, 1);
    check_eq("rst_wr_en", o_wr_en, 1);
    check_eq("rst_wr_index", o_wr_index, 0);
    check_eq("rst_flush_done", o_flush_done, 0);
    check_eq("rst_store_ready", o_store_ready, 0);
    check_eq("rst_fill_ready", o_fill_ready, 0);
    next_cycle();
    i_rst = 1'b0;

    run_sweep(-1, bad_a, done_a);
    check_eq("init_sweep_bad", bad_a, 0);
    check_eq("init_sweep_done", done_a, 0);
    @(negedge clk);
    check_eq("idle_busy", o_busy, 0);
    check_eq("idle_wr_en", o_wr_en, 0);
    check_eq("idle_store_ready", o_store_ready, 1);
    check_eq("idle_fill_ready", o_fill_ready, 1);
    check_eq("idle_flush_done", o_flush_done, 0);
    next_cycle();

    // Tag-hit store merges valid bits.
    i_store_valid = 1'b1; i_store_addr = 32'h0000_0104; i_store_byte_en = 4'b0011;
    i_store_data = 32'hA5A5_1234; i_rd_tag = 7'd0; i_rd_valid_bits = 4'b1100;
    @(negedge clk);
    check_eq("merge_rd_index", o_rd_index, 65);
    check_eq("merge_wr_en", o_wr_en, 1);
    check_eq("merge_wr_index", o_wr_index, 65);
    check_eq("merge_valid", o_wr_valid_bits, 4'b1111);
    check_eq("merge_byte_en", o_wr_data_byte_en, 4'b0011);
    check_eq("merge_data", o_wr_data, 32'hA5A5_1234);
    next_cycle();

    // Tag-miss store replaces valid bits.
    i_store_addr = 32'h0000_0A08; i_store_byte_en = 4'b0100; i_rd_valid_bits = 4'b1011;
    @(negedge clk);
    check_eq("miss_wr_index", o_wr_index, 2);
    check_eq("miss_tag", o_wr_tag, 5);
    check_eq("miss_valid", o_wr_valid_bits, 4'b0100);
    check_eq("miss_byte_en", o_wr_data_byte_en, 4'b0100);
    next_cycle();

    // Store beats fill; fill accepted next cycle.
    i_store_addr = 32'h0000_000C; i_store_byte_en = 4'b1111;
    i_fill_valid = 1'b1; i_fill_addr = 32'h0000_0424; i_fill_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("conf_fill_ready", o_fill_ready, 0);
    check_eq("conf_store_ready", o_store_ready, 1);
    check_eq("conf_wr_index", o_wr_index, 3);
    next_cycle();
    i_store_valid = 1'b0;
    @(negedge clk);
    check_eq("fill_ready", o_fill_ready, 1);
    check_eq("fill_wr_en", o_wr_en, 1);
    check_eq("fill_wr_index", o_wr_index, 9);
    check_eq("fill_tag", o_wr_tag, 2);
    check_eq("fill_valid", o_wr_valid_bits, 4'b1111);
    check_eq("fill_byte_en", o_wr_data_byte_en, 4'b1111);
    check_eq("fill_data", o_wr_data, 32'hDEAD_BEEF);
    next_cycle();
    i_fill_valid = 1'b0;

    // Uncacheable accesses are accepted without writing.
    i_store_valid = 1'b1; i_store_addr = 32'h4000_0000;
    @(negedge clk);
    check_eq("mmio_store_ready", o_store_ready, 1);
    check_eq("mmio_store_wr_en", o_wr_en, 0);
    next_cycle();
    i_store_addr = 32'h3FFF_FFFC;
    @(negedge clk);
    check_eq("hi_store_wr_en", o_wr_en, 0);
    next_cycle();
    i_store_valid = 1'b0; i_fill_valid = 1'b1; i_fill_addr = 32'h0001_0000;
    @(negedge clk);
    check_eq("unc_fill_ready", o_fill_ready, 1);
    check_eq("unc_fill_wr_en", o_wr_en, 0);
    next_cycle();
    i_fill_addr = 32'h0000_FFFC;
    @(negedge clk);
    check_eq("top_fill_wr_en", o_wr_en, 1);
    check_eq("top_fill_index", o_wr_index, 127);
    check_eq("top_fill_tag", o_wr_tag, 127);
    next_cycle();
    i_fill_valid = 1'b0;

    // Flush request with a same-cycle store; second request at index 50 chains a sweep.
    i_flush_req = 1'b1; i_store_valid = 1'b1; i_store_addr = 32'h0000_0010;
    @(negedge clk);
    check_eq("flreq_wr_en", o_wr_en, 1);
    check_eq("flreq_wr_index", o_wr_index, 4);
    next_cycle();
    run_sweep(50, bad_a, done_a);
    run_sweep(-1, bad_b, done_b);
    i_store_valid = 1'b0;
    check_eq("flush_sweep1_bad", bad_a, 0);
    check_eq("flush_sweep2_bad", bad_b, 0);
    check_eq("flush_early_done", done_a + done_b, 0);
    @(negedge clk);
    check_eq("flush_done_pulse", o_flush_done, 1);
    check_eq("flush_done_busy", o_busy, 0);
    next_cycle();
    @(negedge clk);
    check_eq("flush_done_clear", o_flush_done, 0);
    next_cycle();

    // Reset at index 70 with a flush pending.
    i_flush_req = 1'b1;
    next_cycle();
    for (int i = 0; i < 70; i++) begin
      i_flush_req = (i == 10);
      next_cycle();
    end
    i_flush_req = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_index70", o_wr_index, 70);
    next_cycle();
    i_rst = 1'b0;
    run_sweep(-1, bad_a, done_a);
    check_eq("midrst_sweep_bad", bad_a, 0);
    check_eq("midrst_sweep_done", done_a, 0);
    @(negedge clk);
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_flush_done", o_flush_done, 0);
    next_cycle();
    @(negedge clk);
    check_eq("midrst_no_pending", o_busy, 0);
    check_eq("midrst_wr_en", o_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
